// File: rtl/sysid_check_ctrl.sv
// Avalon-MM sequencer: reads sysid word 0 (ID) and word 1 (timestamp), compares against build constants.
// Optional macro SYSID_AUTO_START_EN issues one internal start right after reset release.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1489607473,
  parameter int          TIMEOUT     = 255,
  parameter int          MAX_RETRY   = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_GAP,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [TO_W-1:0]   r_to_cnt;
  logic [RT_W-1:0]   r_rt_cnt;
  logic              r_cur_ts;
  logic              r_id_got;
  logic              r_ts_got;
  logic [31:0]       r_id_value;
  logic [31:0]       r_ts_value;
  logic              r_id_ok;
  logic              r_ts_ok;
  logic              r_pass;
  logic              r_timeout_err;
  logic              w_start;
  logic              w_in_rd;
  logic              w_accept;
  logic              w_expire;
  logic              w_retry_ok;

`ifdef SYSID_AUTO_START_EN
  logic [1:0] r_rel;

  // Two-flop release shifter; the rising edge of its output is the internal start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rel <= 2'b00;
    end else begin
      r_rel <= {r_rel[0], 1'b1};
    end
  end

  assign w_start = start | (r_rel[0] & ~r_rel[1]);
`else
  assign w_start = start;
`endif

  assign w_in_rd    = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  assign w_accept   = w_in_rd && !avm_waitrequest;
  assign w_expire   = w_in_rd && avm_waitrequest && (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_retry_ok = (r_rt_cnt < RT_W'(MAX_RETRY));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_RD_ID;
      S_RD_ID: begin
        if (w_accept)      w_next = S_RD_TS;
        else if (w_expire) w_next = S_GAP;
      end
      S_RD_TS: begin
        if (w_accept)      w_next = S_DONE;
        else if (w_expire) w_next = S_GAP;
      end
      S_GAP: begin
        if (w_retry_ok) w_next = r_cur_ts ? S_RD_TS : S_RD_ID;
        else            w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Flags are loaded on entry to DONE so they are already valid alongside the done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt      <= '0;
      r_rt_cnt      <= '0;
      r_cur_ts      <= 1'b0;
      r_id_got      <= 1'b0;
      r_ts_got      <= 1'b0;
      r_id_value    <= '0;
      r_ts_value    <= '0;
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_to_cnt      <= '0;
            r_rt_cnt      <= '0;
            r_cur_ts      <= 1'b0;
            r_id_got      <= 1'b0;
            r_ts_got      <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout_err <= 1'b0;
          end
        end
        S_RD_ID, S_RD_TS: begin
          if (w_accept) begin
            r_to_cnt <= '0;
            r_rt_cnt <= '0;
            if (r_state == S_RD_ID) begin
              r_id_value <= avm_readdata;
              r_id_got   <= 1'b1;
              r_cur_ts   <= 1'b1;
            end else begin
              r_ts_value <= avm_readdata;
              r_ts_got   <= 1'b1;
              r_id_ok    <= r_id_got && (r_id_value == EXPECTED_ID);
              r_ts_ok    <= (avm_readdata == EXPECTED_TS);
              r_pass     <= r_id_got && (r_id_value == EXPECTED_ID) &&
                            (avm_readdata == EXPECTED_TS) && !r_timeout_err;
            end
          end else if (w_expire) begin
            r_to_cnt <= '0;
          end else if (avm_waitrequest) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (w_retry_ok) begin
            r_rt_cnt <= r_rt_cnt + 1'b1;
          end else begin
            r_timeout_err <= 1'b1;
            r_id_ok       <= r_id_got && (r_id_value == EXPECTED_ID);
            r_ts_ok       <= r_ts_got && (r_ts_value == EXPECTED_TS);
            r_pass        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign avm_read    = w_in_rd;
  assign avm_address = (r_state == S_RD_TS);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign pass        = r_pass;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Self-checking bench for sysid_check_ctrl: vector table plus hand-written timing sequences,
// done-time results compared from a scoreboard queue against a configurable stalling slave.
`timescale 1ns/1ps
module tb_sysid_check_ctrl;

  localparam int          TO     = 4;
  localparam int          MR     = 2;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1489607473;
  localparam int          NV     = 11;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        id_ok;
  logic        ts_ok;
  logic        pass;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] sl_id = 32'd0;
  logic [31:0] sl_ts = 32'd0;
  int sl_stall0 = 0;
  int sl_stall1 = 0;
  int sl_cnt;

  typedef struct {
    logic [31:0] id_v;
    logic [31:0] ts_v;
    logic        id_ok;
    logic        ts_ok;
    logic        pass;
    logic        terr;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] id_w;
    logic [31:0] ts_w;
    int          s0;
    int          s1;
    logic [31:0] e_id;
    logic [31:0] e_ts;
    logic        e_idok;
    logic        e_tsok;
    logic        e_pass;
    logic        e_terr;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[NV];

  sysid_check_ctrl #(
    .EXPECTED_ID (EXP_ID),
    .EXPECTED_TS (EXP_TS),
    .TIMEOUT     (TO),
    .MAX_RETRY   (MR)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .pass            (pass),
    .timeout_err     (timeout_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave stalls the first sl_stallN cycles of each word; the count survives read gaps.
  assign avm_readdata    = avm_address ? sl_ts : sl_id;
  assign avm_waitrequest = avm_read && (sl_cnt < (avm_address ? sl_stall1 : sl_stall0));

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          sl_cnt <= 0;
    else if (!busy)                        sl_cnt <= 0;
    else if (avm_read && !avm_waitrequest) sl_cnt <= 0;
    else if (avm_read)                     sl_cnt <= sl_cnt + 1;
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk1("unexpected_done", done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk32("id_value", id_value, e.id_v);
        chk32("ts_value", ts_value, e.ts_v);
        chk1("id_ok", id_ok, e.id_ok);
        chk1("ts_ok", ts_ok, e.ts_ok);
        chk1("pass", pass, e.pass);
        chk1("timeout_err", timeout_err, e.terr);
        if (e.cyc >= 0) chk32("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_done(input int budget, input string nm);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk1({nm, "_done_seen"}, done, 1'b1);
    @(negedge clock);
  endtask

  // Pushes the expectation and pulses start; returns at the negedge of T1.
  task automatic launch(input vec_t v);
    sl_id     = v.id_w;
    sl_ts     = v.ts_w;
    sl_stall0 = v.s0;
    sl_stall1 = v.s1;
    @(negedge clock);
    sb.push_back('{v.e_id, v.e_ts, v.e_idok, v.e_tsok, v.e_pass, v.e_terr, cyc + v.lat});
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    vec_t  v;
    logic [15:0] pat;
    logic [11:0] ctl;
    logic        stable;
    int          ndone;

    vt[0]  = '{32'd0, EXP_TS,         0,   0,   32'd0, EXP_TS,         1'b1, 1'b1, 1'b1, 1'b0, 3};
    vt[1]  = '{32'd0, 32'h12345678,   0,   0,   32'd0, 32'h12345678,   1'b1, 1'b0, 1'b0, 1'b0, 3};
    vt[2]  = '{32'd0, EXP_TS,         0,   3,   32'd0, EXP_TS,         1'b1, 1'b1, 1'b1, 1'b0, 6};
    vt[3]  = '{32'd1, EXP_TS,         2,   0,   32'd1, EXP_TS,         1'b0, 1'b1, 1'b0, 1'b0, 5};
    vt[4]  = '{32'd0, EXP_TS,         3,   0,   32'd0, EXP_TS,         1'b1, 1'b1, 1'b1, 1'b0, 6};
    vt[5]  = '{32'd0, EXP_TS,         4,   0,   32'd0, EXP_TS,         1'b1, 1'b1, 1'b1, 1'b0, 8};
    vt[6]  = '{32'd0, EXP_TS,         6,   0,   32'd0, EXP_TS,         1'b1, 1'b1, 1'b1, 1'b0, 10};
    vt[7]  = '{32'd0, EXP_TS,         8,   0,   32'd0, EXP_TS,         1'b1, 1'b1, 1'b1, 1'b0, 13};
    vt[8]  = '{32'd0, EXP_TS,         100, 0,   32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 16};
    vt[9]  = '{32'd0, EXP_TS,         0,   100, 32'd0, 32'd0,          1'b1, 1'b0, 1'b0, 1'b1, 17};
    vt[10] = '{32'd0, 32'd1489607472, 0,   0,   32'd0, 32'd1489607472, 1'b1, 1'b0, 1'b0, 1'b0, 3};

    reset_n = 1'b0;
    start   = 1'b0;
    sl_id   = 32'd0;
    sl_ts   = EXP_TS;
    repeat (3) @(negedge clock);
    chk32("reset_outputs",
          {avm_read, avm_address, busy, done, id_ok, ts_ok, pass, timeout_err} | id_value | ts_value,
          32'd0);
`ifdef SYSID_AUTO_START_EN
    sb.push_back('{32'd0, EXP_TS, 1'b1, 1'b1, 1'b1, 1'b0, -1});
    reset_n = 1'b1;
    wait_done(20, "auto_start");
`else
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk1("idle_no_autostart", busy, 1'b0);
`endif

    // Zero-wait cycle timing and result hold in IDLE.
    launch(vt[0]);
    ctl[11:9] = {avm_read, avm_address, busy};
    @(negedge clock);
    ctl[8:6] = {avm_read, avm_address, busy};
    @(negedge clock);
    ctl[5:3] = {avm_read, avm_address, busy};
    @(negedge clock);
    ctl[2:0] = {avm_read, avm_address, busy};
    chk32("zero_wait_timing", {20'd0, ctl}, {20'd0, 12'b101_111_001_000});
    repeat (3) @(negedge clock);
    chk32("hold_ts_value", ts_value, EXP_TS);
    chk1("hold_pass", pass, 1'b1);

    for (int i = 0; i < NV; i++) begin
      launch(vt[i]);
      wait_done(30, "vector");
      @(negedge clock);
    end

    // Three-cycle stall on the timestamp read: strobe and address held steady.
    launch(vt[2]);
    @(negedge clock);
    stable = 1'b1;
    for (int t = 2; t <= 5; t++) begin
      if (!(avm_read === 1'b1 && avm_address === 1'b1)) stable = 1'b0;
      if (t < 5) @(negedge clock);
    end
    chk1("stall_stable", stable, 1'b1);
    wait_done(10, "stall");

    // Stuck slave: three 4-cycle attempts, one-cycle gaps, then done.
    launch(vt[8]);
    pat = '0;
    stable = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      pat = {pat[14:0], avm_read};
      if (avm_address !== 1'b0) stable = 1'b0;
      if (t < 16) @(negedge clock);
    end
    chk32("timeout_read_pattern", {16'd0, pat}, 32'h0000_F7BC);
    chk1("timeout_addr0", stable, 1'b1);
    @(negedge clock);

    // Start pulsed during RD_TS must not queue a second run.
    v = vt[2];
    v.s1 = 2;
    v.lat = 5;
    launch(v);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    for (int t = 3; t <= 14; t++) begin
      if (done === 1'b1) ndone++;
      @(negedge clock);
    end
    chk32("start_in_rd_ts_done_count", 32'(ndone), 32'd1);

    // Reset in RD_ID clears everything in the same cycle.
    sl_stall0 = 100;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk1("pre_reset_read", avm_read, 1'b1);
    reset_n = 1'b0;
    #1;
    chk32("async_reset_outputs",
          {avm_read, avm_address, busy, done, id_ok, ts_ok, pass, timeout_err} | id_value | ts_value,
          32'd0);
    @(negedge clock);
    @(negedge clock);
    sl_stall0 = 0;
`ifdef SYSID_AUTO_START_EN
    sb.push_back('{32'd0, EXP_TS, 1'b1, 1'b1, 1'b1, 1'b0, -1});
    reset_n = 1'b1;
    wait_done(20, "auto_restart");
`else
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk1("idle_after_reset", busy, 1'b0);
`endif

    launch(vt[1]);
    wait_done(10, "post_reset");
    repeat (2) @(negedge clock);
    chk32("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
Avalon-MM master sequencer that reads the system-ID slave after reset or on request and verifies the build. Reads word 0 (ID) then word 1 (timestamp) and compares both against expected constants. Reports pass/fail to the boot logic or a status LED/PIO. Includes per-access timeout and bounded retry so a hung or absent slave never stalls boot.

Parameters:
EXPECTED_ID, 0, value the slave must return at address 0
EXPECTED_TS, 1489607473, value the slave must return at address 1
TIMEOUT, 255, max cycles one read may stall on waitrequest (1..65535)
MAX_RETRY, 3, retries allowed per read after a timeout (0..15)

Ports:
clock  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run a check; ignored while busy
avm_address  out  1  word address to sysid slave (0=ID, 1=timestamp)
avm_read  out  1  Avalon read strobe
avm_readdata  in  32  read data, valid in any cycle with avm_read=1 and avm_waitrequest=0
avm_waitrequest  in  1  slave stall
busy  out  1  high from cycle after accepted start through DONE
done  out  1  one-cycle pulse when results valid
id_value  out  32  captured ID word
ts_value  out  32  captured timestamp word
id_ok  out  1  id_value == EXPECTED_ID
ts_ok  out  1  ts_value == EXPECTED_TS
pass  out  1  id_ok & ts_ok & ~timeout_err
timeout_err  out  1  retries exhausted on either read

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, avm_read drops immediately, counters 0.
- States: IDLE, RD_ID, RD_TS, GAP, DONE.
- IDLE: start=1 -> RD_ID; clear id_value, ts_value, id_ok, ts_ok, pass, timeout_err, retry counter.
- RD_ID: avm_read=1, avm_address=0, both held stable while waitrequest=1. Accepting edge (waitrequest=0): capture readdata into id_value, reset timeout and retry counters, -> RD_TS.
- RD_TS: same with avm_address=1; capture into ts_value, -> DONE.
- Timeout: counter increments each cycle in RD_* with waitrequest=1; when it reaches TIMEOUT with waitrequest still 1, read is abandoned -> GAP (avm_read=0 exactly one cycle). If retry count < MAX_RETRY: increment, return to the same RD_* state. Else: timeout_err=1 -> DONE; unread value stays 0 and its _ok flag stays 0.
- DONE: done=1 one cycle; id_ok, ts_ok, pass registered from captured values this cycle; -> IDLE. busy=0 in IDLE.
- Zero-wait latency: start at T0 -> read addr0 at T1 -> read addr1 at T2 -> done at T3.
- Results held stable in IDLE until next accepted start.
- start while busy (RD_*, GAP, DONE): ignored, not queued.
- Counter widths: clog2(TIMEOUT+1) and clog2(MAX_RETRY+1); no wrap possible since reset on each accept/retry.
- Compare is full 32-bit equality; no masking.

Optional Feature:
SYSID_AUTO_START_EN: when defined, an internal one-cycle start is issued in the first cycle after reset_n deasserts (synchronised via a 2-flop release register), so check runs with no external start; external start remains usable afterwards. When undefined, the check runs only on external start.

Test Plan:
- Zero-wait slave returning 0 / 1489607473, pulse start -> read addr0 at T1, addr1 at T2, done at T3, id_ok=ts_ok=pass=1, busy T1..T3.
- Slave returns ts 0x12345678 -> done with id_ok=1, ts_ok=0, pass=0, ts_value=0x12345678.
- waitrequest held 3 cycles on addr1 -> avm_read/avm_address stable throughout, capture on 4th cycle, pass=1, done at T6.
- waitrequest stuck high, TIMEOUT=4, MAX_RETRY=2 -> three read attempts of 4 cycles each separated by one-cycle read=0 gaps, then done, timeout_err=1, pass=0, id_value=0.
- start pulsed during RD_TS -> ignored, exactly one done pulse; reset_n low in RD_ID -> avm_read=0 and all outputs 0 same cycle, FSM IDLE after release.
- With SYSID_AUTO_START_EN: release reset, no start -> read sequence begins without stimulus, done with pass=1.
